// File: rtl/fwd_scoreboard.sv
// ID-stage operand forwarding and hazard unit: picks each source operand from the youngest
// in-flight producer, the long-latency writeback bypass or the register file, and tracks multi-cycle busy registers.
module fwd_scoreboard #(
    parameter  int NUM_SRC = 2,
    parameter  int NUM_FWD = 2,
    parameter  int XLEN    = 64,
    parameter  int NREG    = 32,
    parameter  int CNT_W   = 32,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*RW-1:0]   fwd_dst,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [NUM_SRC*RW-1:0]   src_idx,
    input  logic [NUM_SRC-1:0]      src_used,
    input  logic [NUM_SRC*XLEN-1:0] src_rf,
    output logic [NUM_SRC*XLEN-1:0] src_out,
    input  logic                    issue_valid,
    input  logic [RW-1:0]           issue_dst,
    input  logic                    issue_long,
    input  logic                    wb_valid,
    input  logic [RW-1:0]           wb_dst,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    output logic                    stall,
    output logic [NREG-1:0]         busy_vec,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic            src_stall;
    logic            waw_hazard;

    // Stages are scanned oldest to youngest so the youngest match overwrites older ones;
    // a not-ready youngest match is a load-use hazard even if an older stage could supply data.
    always_comb begin : operand_select
        logic [RW-1:0]   idx;
        logic [XLEN-1:0] sel;
        logic            load_use;
        logic            busy_hit;
        idx       = '0;
        sel       = '0;
        load_use  = 1'b0;
        busy_hit  = 1'b0;
        src_out   = '0;
        src_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx      = src_idx[i*RW +: RW];
            sel      = src_rf[i*XLEN +: XLEN];
            load_use = 1'b0;
            if (wb_valid && wb_dst == idx && wb_dst != '0) begin
                sel = wb_data;
            end
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && fwd_dst[k*RW +: RW] != '0 && fwd_dst[k*RW +: RW] == idx) begin
                    sel      = fwd_data[k*XLEN +: XLEN];
                    load_use = !fwd_ready[k];
                end
            end
            if (idx == '0) begin
                sel      = '0;
                load_use = 1'b0;
            end
            busy_hit = busy_q[idx] && !(wb_valid && wb_dst == idx);
            src_out[i*XLEN +: XLEN] = sel;
            if (src_used[i] && (load_use || busy_hit)) begin
                src_stall = 1'b1;
            end
        end
    end

    assign waw_hazard = issue_valid && issue_dst != '0 && busy_q[issue_dst] &&
                        !(wb_valid && wb_dst == issue_dst);
    assign stall      = src_stall || waw_hazard;
    assign busy_vec   = busy_q;

    // Clear on writeback first so a same-cycle re-issue to that register keeps it busy.
    always_comb begin
        busy_next = busy_q;
        if (wb_valid) begin
            busy_next[wb_dst] = 1'b0;
        end
        if (issue_valid && issue_long && issue_dst != '0 && !stall) begin
            busy_next[issue_dst] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                busy_q <= '0;
            end else begin
                busy_q <= busy_next;
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expected values are queued as stimulus is driven
// and popped against DUT outputs once they settle.
module tb_fwd_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int CNT_W   = 4;
    localparam int RW      = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_FWD-1:0]      fwd_valid;
    logic [NUM_FWD*RW-1:0]   fwd_dst;
    logic [NUM_FWD-1:0]      fwd_ready;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [NUM_SRC*RW-1:0]   src_idx;
    logic [NUM_SRC-1:0]      src_used;
    logic [NUM_SRC*XLEN-1:0] src_rf;
    logic [NUM_SRC*XLEN-1:0] src_out;
    logic                    issue_valid;
    logic [RW-1:0]           issue_dst;
    logic                    issue_long;
    logic                    wb_valid;
    logic [RW-1:0]           wb_dst;
    logic [XLEN-1:0]         wb_data;
    logic                    flush;
    logic                    stall;
    logic [NREG-1:0]         busy_vec;
    logic [CNT_W-1:0]        stall_cnt;

    string       tag_q[$];
    logic [63:0] want_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .src_idx(src_idx), .src_used(src_used), .src_rf(src_rf), .src_out(src_out),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_long(issue_long),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .flush(flush),
        .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        fwd_valid = '0; fwd_dst = '0; fwd_ready = '0; fwd_data = '0;
        src_idx = '0; src_used = '0; src_rf = '0;
        issue_valid = 1'b0; issue_dst = '0; issue_long = 1'b0;
        wb_valid = 1'b0; wb_dst = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic setFwd(input int k, input logic v, input logic [RW-1:0] dst,
                          input logic rdy, input logic [XLEN-1:0] data);
        fwd_valid[k]             = v;
        fwd_dst[k*RW +: RW]      = dst;
        fwd_ready[k]             = rdy;
        fwd_data[k*XLEN +: XLEN] = data;
    endtask

    task automatic applyStimulus(input int i, input logic [RW-1:0] idx, input logic used,
                                 input logic [XLEN-1:0] rf);
        src_idx[i*RW +: RW]    = idx;
        src_used[i]            = used;
        src_rf[i*XLEN +: XLEN] = rf;
    endtask

    task automatic expectVal(input string tag, input logic [63:0] val);
        tag_q.push_back(tag);
        want_q.push_back(val);
    endtask

    task automatic checkOutput(input logic [63:0] observed);
        string       tag;
        logic [63:0] want;
        checks++;
        if (want_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL underflow observed=%0h with no queued expectation", observed);
            return;
        end
        tag  = tag_q.pop_front();
        want = want_q.pop_front();
        assert (observed === want) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, want);
        end
    endtask

    function automatic logic [63:0] src0();
        return src_out[0 +: XLEN];
    endfunction

    function automatic logic [63:0] src1();
        return src_out[XLEN +: XLEN];
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state with idle forwarding inputs
        expectVal("rst_busy", 64'h0);
        expectVal("rst_cnt", 64'h0);
        expectVal("rst_stall", 64'h0);
        settle();
        checkOutput(64'(busy_vec));
        checkOutput(64'(stall_cnt));
        checkOutput(64'(stall));
        tick();

        // Youngest producer wins; x0 reads as zero
        setFwd(0, 1'b1, 5'd5, 1'b1, 64'hA);
        setFwd(1, 1'b1, 5'd5, 1'b1, 64'hB);
        applyStimulus(0, 5'd5, 1'b1, 64'hF0);
        applyStimulus(1, 5'd0, 1'b1, 64'hF1);
        expectVal("young_src0", 64'hA);
        expectVal("young_stall", 64'h0);
        expectVal("x0_src1", 64'h0);
        settle();
        checkOutput(src0());
        checkOutput(64'(stall));
        checkOutput(src1());
        tick();

        // Older stage only, writeback bypass, and plain register file
        idle();
        setFwd(1, 1'b1, 5'd5, 1'b1, 64'hB);
        applyStimulus(0, 5'd5, 1'b1, 64'hF0);
        wb_valid = 1'b1; wb_dst = 5'd12; wb_data = 64'h77;
        applyStimulus(1, 5'd12, 1'b1, 64'h99);
        expectVal("old_src0", 64'hB);
        expectVal("wb_src1", 64'h77);
        settle();
        checkOutput(src0());
        checkOutput(src1());
        applyStimulus(1, 5'd13, 1'b1, 64'h99);
        expectVal("rf_src1", 64'h99);
        settle();
        checkOutput(src1());
        tick();

        // Load-use on the youngest match masks an older ready producer
        idle();
        setFwd(0, 1'b1, 5'd7, 1'b0, 64'h0);
        setFwd(1, 1'b1, 5'd7, 1'b1, 64'hC);
        applyStimulus(1, 5'd7, 1'b1, 64'h0);
        expectVal("loaduse_stall", 64'h1);
        settle();
        checkOutput(64'(stall));
        applyStimulus(1, 5'd7, 1'b0, 64'h0);
        expectVal("loaduse_unused", 64'h0);
        settle();
        checkOutput(64'(stall));
        tick();

        // Long op to x9, busy source stalls until writeback
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        issue_valid = 1'b1; issue_dst = 5'd9; issue_long = 1'b1;
        expectVal("issue9_stall", 64'h0);
        settle();
        checkOutput(64'(stall));
        tick();
        idle();
        applyStimulus(0, 5'd9, 1'b1, 64'h0);
        for (int t = 1; t <= 3; t++) begin
            expectVal("busy9_stall", 64'h1);
            expectVal("busy9_vec", 64'h200);
            settle();
            checkOutput(64'(stall));
            checkOutput(64'(busy_vec));
            tick();
        end
        wb_valid = 1'b1; wb_dst = 5'd9; wb_data = 64'h55;
        expectVal("wb9_src0", 64'h55);
        expectVal("wb9_stall", 64'h0);
        settle();
        checkOutput(src0());
        checkOutput(64'(stall));
        tick();
        idle();
        expectVal("wb9_busy_clr", 64'h0);
        expectVal("wb9_cnt", 64'h3);
        settle();
        checkOutput(64'(busy_vec));
        checkOutput(64'(stall_cnt));
        tick();

        // WAW: stalls without writeback, set wins over same-cycle clear
        issue_valid = 1'b1; issue_dst = 5'd9; issue_long = 1'b1;
        tick();
        expectVal("waw_stall", 64'h1);
        settle();
        checkOutput(64'(stall));
        wb_valid = 1'b1; wb_dst = 5'd9; wb_data = 64'h1;
        expectVal("waw_wb_stall", 64'h0);
        settle();
        checkOutput(64'(stall));
        tick();
        idle();
        expectVal("set_wins", 64'h200);
        settle();
        checkOutput(64'(busy_vec));

        // Build busy {x3,x4}, then flush ignores same-cycle wb and issue
        wb_valid = 1'b1; wb_dst = 5'd9;
        issue_valid = 1'b1; issue_dst = 5'd3; issue_long = 1'b1;
        tick();
        idle();
        issue_valid = 1'b1; issue_dst = 5'd4; issue_long = 1'b1;
        tick();
        idle();
        expectVal("busy34", 64'h18);
        settle();
        checkOutput(64'(busy_vec));
        flush = 1'b1;
        wb_valid = 1'b1; wb_dst = 5'd3;
        issue_valid = 1'b1; issue_dst = 5'd6; issue_long = 1'b1;
        expectVal("flush_stall", 64'h0);
        settle();
        checkOutput(64'(stall));
        tick();
        idle();
        setFwd(0, 1'b1, 5'd0, 1'b1, 64'hDEAD);
        wb_valid = 1'b1; wb_dst = 5'd0; wb_data = 64'h77;
        applyStimulus(0, 5'd0, 1'b1, 64'h1234);
        applyStimulus(1, 5'd6, 1'b1, 64'h66);
        expectVal("flush_busy", 64'h0);
        expectVal("x0_dst0", 64'h0);
        expectVal("x6_not_busy", 64'h66);
        expectVal("x6_stall", 64'h0);
        settle();
        checkOutput(64'(busy_vec));
        checkOutput(src0());
        checkOutput(src1());
        checkOutput(64'(stall));
        tick();

        // Counter saturation, flush does not mask or clear it
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        issue_valid = 1'b1; issue_dst = 5'd2; issue_long = 1'b1;
        tick();
        idle();
        setFwd(0, 1'b1, 5'd7, 1'b0, 64'h0);
        applyStimulus(0, 5'd7, 1'b1, 64'h0);
        for (int n = 1; n <= 20; n++) begin
            flush = (n == 11);
            tick();
            if (n == 10) begin
                expectVal("cnt10", 64'd10);
                checkOutput(64'(stall_cnt));
            end
            if (n == 11) begin
                expectVal("cnt_flush", 64'd11);
                checkOutput(64'(stall_cnt));
            end
        end
        expectVal("cnt_sat", 64'd15);
        checkOutput(64'(stall_cnt));
        idle();
        issue_valid = 1'b1; issue_dst = 5'd2; issue_long = 1'b1;
        tick();
        idle();
        expectVal("reissue_busy", 64'h4);
        expectVal("cnt_held", 64'd15);
        settle();
        checkOutput(64'(busy_vec));
        checkOutput(64'(stall_cnt));

        // Mid-operation reset clears busy and counter; stall still follows fwd inputs
        setFwd(0, 1'b1, 5'd7, 1'b0, 64'h0);
        applyStimulus(0, 5'd7, 1'b1, 64'h0);
        issue_valid = 1'b1; issue_dst = 5'd5; issue_long = 1'b1;
        reset = 1'b0;
        expectVal("rst_low_stall", 64'h1);
        settle();
        checkOutput(64'(stall));
        tick();
        expectVal("rst_mid_busy", 64'h0);
        expectVal("rst_mid_cnt", 64'h0);
        checkOutput(64'(busy_vec));
        checkOutput(64'(stall_cnt));
        reset = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
